seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter CLK_DIV, default 100000: clock cycles each digit is displayed, legal range >= 2.
REQ-003 Parameter AN_ACTIVE_LOW, default 1: 1 means the enabled anode is driven 0; 0 means it is driven 1.
REQ-004 clk  in  1  single clock; all state advances on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 value  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k, and digit 0 is least significant.
REQ-007 dp_mask  in  DIGITS  bit k=1 lights the decimal point of digit k; sampled together with value.
REQ-008 lz_en  in  1  1 enables leading-zero suppression; sampled live every cycle.
REQ-009 load  in  1  one-cycle request to capture value and dp_mask.
REQ-010 light  out  8  segment drive; bit7=a .. bit1=g, bit0=dp; 0 means lit.
REQ-011 an  out  DIGITS  one-hot digit enable, polarity set by AN_ACTIVE_LOW.
REQ-012 frame_done  out  1  one-cycle pulse when digit DIGITS-1 finishes its slot.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps; the cycle at CLK_DIV-1 is the "tick".
REQ-014 Digit index idx advances by 1 on each tick and wraps from DIGITS-1 to 0; the tick that wraps it is the "frame wrap".
REQ-015 frame_done is registered and asserts for exactly one cycle, in the cycle after the frame wrap.
REQ-016 Shadow registers (value and dp_mask) update only on a frame wrap, and only when a load is pending or load=1 in that same cycle.
REQ-017 Load pending flag: set by load=1; cleared on the frame wrap that consumes it; load=1 on a consuming wrap is absorbed and leaves pending clear.
REQ-018 Multiple loads within one frame collapse into one capture, which takes value as present on the consuming wrap cycle.
REQ-019 Segment code for nibble 0..F is 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex); bit0 is then cleared when the digit's dp bit is 1.
REQ-020 Leading-zero suppression: with lz_en=1, digit k>0 is blanked when shadow nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked. Blank code is FF, with the dp still applied.
REQ-021 light and an are registered functions of (idx, shadow, lz_en) with 1-cycle latency; exactly one an bit is active outside reset.
REQ-022 When DIGITS=1, idx stays 0, and every tick is a frame wrap.

Reset
REQ-023 rst_n low immediately forces: prescaler 0, idx 0, pending 0, shadow value 0, shadow dp 0, light FF, an all inactive, frame_done 0.
REQ-024 After rst_n deasserts, the first clock edge drives digit 0 with code 03 (or 02 if dp), and an bit 0 becomes active.
REQ-025 Reset asserted mid-frame discards any pending load; no partial capture survives.

Structure
REQ-026 A shared package seg_pkg holds the 16-entry segment table, SEG_BLANK=8'hFF and the DP bit index constant.
REQ-027 One sub-module seg_hex7 (combinational nibble -> 8-bit code with dp input) is instantiated once, on the selected digit.
REQ-028 Prescaler width is $clog2(CLK_DIV) and idx width is $clog2(DIGITS) (minimum 1).

Verification (DIGITS=4, CLK_DIV=4, AN_ACTIVE_LOW=1)
REQ-029 Reset release, no load -> an cycles E,D,B,7 every 4 clocks; light=03 throughout; frame_done pulses every 16 clocks.
REQ-030 value=16'h12AF, load mid-frame -> unchanged until next wrap; then digits show 71,11,25,9F (digit 0..3).
REQ-031 value=16'h0050, lz_en=1, dp_mask=4'b1000 -> digit0 03, digit1 49, digit2 FF, digit3 FE.
REQ-032 load on the frame wrap cycle with value=16'h0007 -> captured that wrap; digit0=1F; pending clear afterwards.
REQ-033 Two loads in one frame (1111 then 2222) -> only 2222 displayed after wrap.
REQ-034 rst_n pulsed low mid-slot with a load pending -> outputs FF and all an inactive at once; after release, value 0 shown and the pending load is lost.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment codes
// (bit7=a .. bit1=g, bit0=dp) and a table lookup helper.
package seg_pkg;

    localparam int         DP_BIT    = 0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [0:15][7:0] SEG_TABLE = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic logic [7:0] seg_lookup(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble to active-low segment code, with blanking and
// decimal point override.
module seg_hex7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] code
);

    always_comb begin
        code = blank ? SEG_BLANK : seg_lookup(nib);
        if (dp) code[DP_BIT] = 1'b0;
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment display scanner: prescaled digit rotation,
// frame-synchronous shadow capture and leading-zero suppression.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int CLK_DIV       = 100000,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [7:0]            light,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;

    logic                tick, wrap, capture;
    logic [4*DIGITS-1:0] upper;
    logic [DIGITS-1:0]   dp_sel, sel_1h, an_next;
    logic                blank;
    logic [7:0]          code;

    assign tick    = (cnt == CNT_LAST);
    assign wrap    = tick && (idx == IDX_LAST);
    assign capture = wrap && (pending || load);

    // Shifting the selected digit to the bottom gives both its nibble and,
    // via the all-zero test, whether every more-significant digit is zero.
    assign upper   = shadow_val >> {idx, 2'b00};
    assign dp_sel  = shadow_dp >> idx;
    assign blank   = lz_en && (idx != '0) && (upper == '0);
    assign sel_1h  = DIGITS'(1) << idx;
    assign an_next = (AN_ACTIVE_LOW != 0) ? ~sel_1h : sel_1h;

    seg_hex7 u_hex7 (
        .nib   (upper[3:0]),
        .dp    (dp_sel[0]),
        .blank (blank),
        .code  (code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            light      <= SEG_BLANK;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;
            // A load landing on the consuming wrap is absorbed by that capture.
            if (wrap)      pending <= 1'b0;
            else if (load) pending <= 1'b1;
            if (capture) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
            end
            frame_done <= wrap;
            light      <= code;
            an         <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (DIGITS=4, CLK_DIV=4): expected digit slots are
// queued by the stimulus; a monitor pops one each time a new anode slot appears.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  light;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan #(.DIGITS(4), .CLK_DIV(4), .AN_ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_mask    (dp_mask),
        .lz_en      (lz_en),
        .load       (load),
        .light      (light),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] light;
        string      name;
    } slot_t;

    slot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;

    logic [3:0] prev_an = 4'hF;
    int         run = 0;
    int         cyc = 0;
    int         last_fd = -1;
    logic       prev_fd = 1'b0;

    // Slot monitor: compare each new digit slot, and check every slot is 4 clocks long.
    always @(negedge clk) begin
        if (an !== prev_an) begin
            if (prev_an != 4'hF && an != 4'hF && rst_n) begin
                checks++;
                if (run != 4) begin
                    errors++;
                    $display("FAIL slot_len: got %0d cycles, expected 4 (an=%h)", run, prev_an);
                end
            end
            if (mon_en && an != 4'hF) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_slot: an=%h light=%h with nothing expected", an, light);
                end else begin
                    slot_t e;
                    e = exp_q.pop_front();
                    if (an !== e.an || light !== e.light) begin
                        errors++;
                        $display("FAIL %s: got an=%h light=%h, expected an=%h light=%h",
                                 e.name, an, light, e.an, e.light);
                    end
                end
            end
            run = 1;
        end else begin
            run++;
        end
        prev_an = an;
    end

    // frame_done: single-cycle pulses exactly 16 clocks apart.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            last_fd = -1;
        end else if (frame_done) begin
            checks++;
            if (prev_fd) begin
                errors++;
                $display("FAIL fd_width: frame_done high on consecutive cycles at %0d", cyc);
            end else if (last_fd >= 0 && cyc - last_fd != 16) begin
                errors++;
                $display("FAIL fd_period: got %0d cycles, expected 16", cyc - last_fd);
            end
            last_fd = cyc;
        end
        prev_fd = frame_done;
    end

    task automatic push_frame(input logic [31:0] codes, input string nm);
        logic [3:0] ans [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int k = 0; k < 4; k++) begin
            slot_t s;
            s.an    = ans[k];
            s.light = codes[8*k +: 8];
            s.name  = $sformatf("%s_d%0d", nm, k);
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d slots never appeared, expected 0 left", nm, exp_q.size());
            exp_q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic wait_fd(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL %s_fd_timeout: frame_done=0, expected 1 within 40 cycles", nm);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (light !== 8'hFF || an !== 4'hF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got light=%h an=%h fd=%b, expected light=ff an=f fd=0",
                     nm, light, an, frame_done);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
        value   = v;
        dp_mask = dp;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    initial begin
        // Reset state, then two idle frames showing zeros.
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset_state");
        push_frame({8'h03, 8'h03, 8'h03, 8'h03}, "idle_f0");
        push_frame({8'h03, 8'h03, 8'h03, 8'h03}, "idle_f1");
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_empty("idle");

        // Mid-frame load holds until the wrap.
        wait_fd("load_mid");
        push_frame({8'h03, 8'h03, 8'h03, 8'h03}, "before_wrap");
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        pulse_load(16'h12AF, 4'b0000);
        wait_empty("before_wrap");
        wait_fd("load_mid2");
        push_frame({8'h9F, 8'h25, 8'h11, 8'h71}, "v12af");
        mon_en = 1'b1;
        wait_empty("v12af");

        // Leading-zero suppression with dp on a blanked digit.
        lz_en = 1'b1;
        pulse_load(16'h0050, 4'b1000);
        wait_fd("lz");
        push_frame({8'hFE, 8'hFF, 8'h49, 8'h03}, "lz0050");
        mon_en = 1'b1;
        wait_empty("lz0050");

        // Load exactly on the wrap cycle, then prove pending stayed clear.
        wait_fd("wrap_load");
        repeat (15) @(negedge clk);
        lz_en = 1'b0;
        pulse_load(16'h0007, 4'b0000);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_align: frame_done=%b, expected 1", frame_done);
        end
        push_frame({8'h03, 8'h03, 8'h03, 8'h1F}, "wrap0007");
        value  = 16'h9999;
        mon_en = 1'b1;
        wait_empty("wrap0007");
        wait_fd("no_pending");
        push_frame({8'h03, 8'h03, 8'h03, 8'h1F}, "still0007");
        mon_en = 1'b1;
        wait_empty("still0007");

        // Two loads in one frame collapse into the later one.
        wait_fd("double");
        repeat (3) @(negedge clk);
        pulse_load(16'h1111, 4'b0000);
        repeat (4) @(negedge clk);
        pulse_load(16'h2222, 4'b0000);
        wait_fd("double2");
        push_frame({8'h25, 8'h25, 8'h25, 8'h25}, "v2222");
        mon_en = 1'b1;
        wait_empty("v2222");

        // Reset mid-slot with a pending load: the load must be lost.
        wait_fd("rst_mid");
        repeat (6) @(negedge clk);
        pulse_load(16'h3333, 4'b1111);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        push_frame({8'h03, 8'h03, 8'h03, 8'h03}, "post_rst_f0");
        push_frame({8'h03, 8'h03, 8'h03, 8'h03}, "post_rst_f1");
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        wait_empty("post_rst");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
